// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline memory port plus SRAM port of the memory access unit
// slave modport: the access unit (takes pipeline requests and SRAM read data, drives the SRAM).
// master modport: the pipeline/SRAM side (drives requests and read data, observes results).
interface mem_access_unit_if #(parameter int DATA_WIDTH = 32, parameter int SRAM_ADDR_WIDTH = 14);
  logic [DATA_WIDTH-1:0] memoryAddress;
  logic [DATA_WIDTH-1:0] memoryDataWrite;
  logic [1:0] memoryLength;
  logic store;
  logic load;
  logic loadUnsigned;
  logic [DATA_WIDTH-1:0] memoryDataRead;
  logic busy;
  logic misaligned;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic sram_re;
  logic sram_we;
  logic [3:0] sram_byteEn;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  modport slave (
    input memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned, sram_rdata,
    output memoryDataRead, busy, misaligned, sram_addr, sram_re, sram_we, sram_byteEn, sram_wdata
  );
  modport master (
    output memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned, sram_rdata,
    input memoryDataRead, busy, misaligned, sram_addr, sram_re, sram_we, sram_byteEn, sram_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store to word SRAM with lane alignment, extension and split accesses
// Ports: clk; reset (async, active-low); bus (mem_access_unit_if.slave: pipeline request/response + SRAM port).
// Optional macro MEM_MISALIGN_TRAP_EN: word-crossing requests are flagged but not executed; split states removed.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_ADDR_WIDTH = 14
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);
`ifdef MEM_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, LOAD_RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_RESP, SPLIT_LD2, SPLIT_LD_RESP, SPLIT_ST2} state_t;
`endif
  state_t state, next;
  logic [1:0] offset, r_off, r_len;
  logic [SRAM_ADDR_WIDTH-1:0] widx;
  logic [2:0] nbytes;
  logic split, ready, accept_st, accept_ld, resp, r_uns;
  logic [3:0] mask;
  logic [63:0] st_wide, rd_wide;
  logic [7:0] mask_wide;
  logic [DATA_WIDTH-1:0] sh, fmt, hold;
  assign offset = bus.memoryAddress[1:0];
  assign widx = bus.memoryAddress[SRAM_ADDR_WIDTH+1:2];
  assign nbytes = bus.memoryLength == 2'd0 ? 3'd1 : bus.memoryLength == 2'd1 ? 3'd2 : 3'd4;
  assign split = {1'b0, offset} + nbytes > 3'd4;
  assign mask = bus.memoryLength == 2'd0 ? 4'h1 : bus.memoryLength == 2'd1 ? 4'h3 : 4'hF;
  // Upper halves of these carry the part of a split store that lands in the next word.
  assign st_wide = {32'b0, bus.memoryDataWrite} << {offset, 3'b0};
  assign mask_wide = {4'b0, mask} << offset;
  // Requests are gated by reset so no enable can leak out while reset is held.
  assign accept_st = reset && ready && bus.store;
  assign accept_ld = reset && ready && bus.load && !bus.store;
  assign sh = 32'(rd_wide >> {r_off, 3'b0});
`ifdef MEM_MISALIGN_TRAP_EN
  logic r_trap;
  assign ready = 1'b1;
  assign bus.busy = 1'b0;
  assign resp = state == LOAD_RESP;
  assign rd_wide = {32'b0, bus.sram_rdata};
  assign fmt = r_trap ? '0 : r_len == 2'd0 ? {{24{~r_uns & sh[7]}}, sh[7:0]} :
               r_len == 2'd1 ? {{16{~r_uns & sh[15]}}, sh[15:0]} : sh;
`else
  logic [SRAM_ADDR_WIDTH-1:0] r_widx2;
  logic [DATA_WIDTH-1:0] r_first, r_hi_data;
  logic [3:0] r_hi_mask;
  assign bus.busy = state == SPLIT_LD2 || state == SPLIT_ST2;
  assign ready = !bus.busy;
  assign resp = state == LOAD_RESP || state == SPLIT_LD_RESP;
  assign rd_wide = state == SPLIT_LD_RESP ? {bus.sram_rdata, r_first} : {32'b0, bus.sram_rdata};
  assign fmt = r_len == 2'd0 ? {{24{~r_uns & sh[7]}}, sh[7:0]} :
               r_len == 2'd1 ? {{16{~r_uns & sh[15]}}, sh[15:0]} : sh;
`endif
  assign bus.memoryDataRead = resp ? fmt : hold;
  always_comb begin
    next = IDLE;
    bus.sram_re = 1'b0;
    bus.sram_we = 1'b0;
    bus.sram_addr = '0;
    bus.sram_byteEn = 4'h0;
    bus.sram_wdata = '0;
    bus.misaligned = 1'b0;
`ifndef MEM_MISALIGN_TRAP_EN
    if (state == SPLIT_LD2) begin
      bus.sram_re = 1'b1;
      bus.sram_addr = r_widx2;
      next = SPLIT_LD_RESP;
    end else if (state == SPLIT_ST2) begin
      bus.sram_we = 1'b1;
      bus.sram_addr = r_widx2;
      bus.sram_byteEn = r_hi_mask;
      bus.sram_wdata = r_hi_data;
    end else
`endif
    if (accept_st) begin
      bus.misaligned = split;
      bus.sram_addr = widx;
      bus.sram_byteEn = mask_wide[3:0];
      bus.sram_wdata = st_wide[31:0];
`ifdef MEM_MISALIGN_TRAP_EN
      bus.sram_we = !split;
`else
      bus.sram_we = 1'b1;
      next = split ? SPLIT_ST2 : IDLE;
`endif
    end else if (accept_ld) begin
      bus.misaligned = split;
      bus.sram_addr = widx;
`ifdef MEM_MISALIGN_TRAP_EN
      bus.sram_re = !split;
      next = LOAD_RESP;
`else
      bus.sram_re = 1'b1;
      next = split ? SPLIT_LD2 : LOAD_RESP;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold <= '0;
      r_off <= 2'd0;
      r_len <= 2'd0;
      r_uns <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_trap <= 1'b0;
`else
      r_widx2 <= '0;
      r_first <= '0;
      r_hi_data <= '0;
      r_hi_mask <= 4'h0;
`endif
    end else begin
      state <= next;
      if (resp) hold <= fmt;
      if (accept_ld) begin
        r_off <= offset;
        r_len <= bus.memoryLength;
        r_uns <= bus.loadUnsigned;
`ifdef MEM_MISALIGN_TRAP_EN
        r_trap <= split;
`endif
      end
`ifndef MEM_MISALIGN_TRAP_EN
      if (accept_ld || accept_st) r_widx2 <= widx + 1'b1;
      if (accept_st) begin
        r_hi_data <= st_wide[63:32];
        r_hi_mask <= mask_wide[7:4];
      end
      if (state == SPLIT_LD2) r_first <= bus.sram_rdata;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a byte-enabled SRAM model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] mem [0:16383];
  mem_access_unit_if #(.DATA_WIDTH(32), .SRAM_ADDR_WIDTH(14)) bus ();
  mem_access_unit #(.DATA_WIDTH(32), .SRAM_ADDR_WIDTH(14)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.sram_we)
      for (int i = 0; i < 4; i++)
        if (bus.sram_byteEn[i]) mem[bus.sram_addr][8*i+:8] = bus.sram_wdata[8*i+:8];
    if (bus.sram_re) bus.sram_rdata <= mem[bus.sram_addr];
  end
  task automatic req(input logic s, input logic l, input logic u, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.store = s;
    bus.load = l;
    bus.loadUnsigned = u;
    bus.memoryLength = len;
    bus.memoryAddress = a;
    bus.memoryDataWrite = d;
    #1;
  endtask
  task automatic nop();
    @(negedge clk);
    bus.store = 1'b0;
    bus.load = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    bus.store = 1'b1;
    bus.load = 1'b0;
    bus.loadUnsigned = 1'b0;
    bus.memoryLength = 2'd2;
    bus.memoryAddress = 32'h47;
    bus.memoryDataWrite = 32'hDEADBEEF;
    #12;
    total++; if (bus.sram_we !== 1'b0) $display("FAIL rst_we got %b exp 0", bus.sram_we); else passed++;
    total++; if (bus.sram_re !== 1'b0) $display("FAIL rst_re got %b exp 0", bus.sram_re); else passed++;
    total++; if (bus.misaligned !== 1'b0) $display("FAIL rst_mis got %b exp 0", bus.misaligned); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else passed++;
    total++; if (bus.sram_addr !== 14'h0) $display("FAIL rst_addr got %h exp 0", bus.sram_addr); else passed++;
    total++; if (bus.memoryDataRead !== 32'h0) $display("FAIL rst_rdata got %h exp 0", bus.memoryDataRead); else passed++;
    bus.store = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_aligned_load();
    req(0, 1, 0, 2'd2, 32'h40, 0);
    total++; if (bus.sram_re !== 1'b1) $display("FAIL lw_re got %b exp 1", bus.sram_re); else passed++;
    total++; if (bus.sram_we !== 1'b0) $display("FAIL lw_we got %b exp 0", bus.sram_we); else passed++;
    total++; if (bus.sram_addr !== 14'h10) $display("FAIL lw_addr got %h exp 10", bus.sram_addr); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL lw_busy0 got %b exp 0", bus.busy); else passed++;
    total++; if (bus.misaligned !== 1'b0) $display("FAIL lw_mis got %b exp 0", bus.misaligned); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h8899AABB) $display("FAIL lw_data got %h exp 8899aabb", bus.memoryDataRead); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL lw_busy1 got %b exp 0", bus.busy); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h8899AABB) $display("FAIL lw_hold got %h exp 8899aabb", bus.memoryDataRead); else passed++;
  endtask
  task automatic test_subword_loads();
    logic [31:0] addrs [4] = '{32'h41, 32'h41, 32'h42, 32'h42};
    logic [1:0] lens [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic unss [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
    for (int k = 0; k < 4; k++) begin
      req(0, 1, unss[k], lens[k], addrs[k], 0);
      nop();
      total++; if (bus.memoryDataRead !== exps[k]) $display("FAIL sub%0d got %h exp %h", k, bus.memoryDataRead, exps[k]); else passed++;
    end
  endtask
  task automatic test_back_to_back();
    req(0, 1, 0, 2'd0, 32'h41, 0);
    req(0, 1, 1, 2'd1, 32'h42, 0);
    total++; if (bus.memoryDataRead !== 32'hFFFFFFAA) $display("FAIL b2b_first got %h exp ffffffaa", bus.memoryDataRead); else passed++;
    total++; if (bus.sram_re !== 1'b1) $display("FAIL b2b_re got %b exp 1", bus.sram_re); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h00008899) $display("FAIL b2b_second got %h exp 00008899", bus.memoryDataRead); else passed++;
  endtask
  task automatic test_split_load();
    req(0, 1, 0, 2'd2, 32'h42, 0);
    total++; if (bus.misaligned !== 1'b1) $display("FAIL sl_mis got %b exp 1", bus.misaligned); else passed++;
    total++; if (bus.sram_addr !== 14'h10) $display("FAIL sl_addr0 got %h exp 10", bus.sram_addr); else passed++;
    total++; if (bus.sram_re !== 1'b1) $display("FAIL sl_re0 got %b exp 1", bus.sram_re); else passed++;
    req(1, 0, 0, 2'd2, 32'h0, 32'h12345678);
    total++; if (bus.busy !== 1'b1) $display("FAIL sl_busy got %b exp 1", bus.busy); else passed++;
    total++; if (bus.sram_addr !== 14'h11) $display("FAIL sl_addr1 got %h exp 11", bus.sram_addr); else passed++;
    total++; if (bus.sram_we !== 1'b0) $display("FAIL sl_ignored_we got %b exp 0", bus.sram_we); else passed++;
    total++; if (bus.misaligned !== 1'b0) $display("FAIL sl_mis1 got %b exp 0", bus.misaligned); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h33448899) $display("FAIL sl_data got %h exp 33448899", bus.memoryDataRead); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL sl_busy2 got %b exp 0", bus.busy); else passed++;
    total++; if (mem[0] !== 32'h0) $display("FAIL sl_nowrite got %h exp 0", mem[0]); else passed++;
  endtask
  task automatic test_split_store();
    mem[14'h12] = 32'hAAAAAAAA;
    req(1, 0, 0, 2'd2, 32'h47, 32'hDEADBEEF);
    total++; if (bus.sram_we !== 1'b1) $display("FAIL ss_we0 got %b exp 1", bus.sram_we); else passed++;
    total++; if (bus.sram_addr !== 14'h11) $display("FAIL ss_addr0 got %h exp 11", bus.sram_addr); else passed++;
    total++; if (bus.sram_byteEn !== 4'b1000) $display("FAIL ss_be0 got %b exp 1000", bus.sram_byteEn); else passed++;
    total++; if (bus.sram_wdata !== 32'hEF000000) $display("FAIL ss_wd0 got %h exp ef000000", bus.sram_wdata); else passed++;
    total++; if (bus.misaligned !== 1'b1) $display("FAIL ss_mis got %b exp 1", bus.misaligned); else passed++;
    nop();
    total++; if (bus.sram_we !== 1'b1 || bus.sram_re !== 1'b0) $display("FAIL ss_we1 got we=%b re=%b exp we=1 re=0", bus.sram_we, bus.sram_re); else passed++;
    total++; if (bus.sram_addr !== 14'h12) $display("FAIL ss_addr1 got %h exp 12", bus.sram_addr); else passed++;
    total++; if (bus.sram_byteEn !== 4'b0111) $display("FAIL ss_be1 got %b exp 0111", bus.sram_byteEn); else passed++;
    total++; if (bus.sram_wdata !== 32'h00DEADBE) $display("FAIL ss_wd1 got %h exp 00deadbe", bus.sram_wdata); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL ss_busy got %b exp 1", bus.busy); else passed++;
    nop();
    total++; if (bus.sram_we !== 1'b0 || bus.busy !== 1'b0) $display("FAIL ss_idle got we=%b busy=%b exp 0 0", bus.sram_we, bus.busy); else passed++;
    total++; if (mem[14'h11] !== 32'hEF223344) $display("FAIL ss_mem0 got %h exp ef223344", mem[14'h11]); else passed++;
    total++; if (mem[14'h12] !== 32'hAADEADBE) $display("FAIL ss_mem1 got %h exp aadeadbe", mem[14'h12]); else passed++;
  endtask
  task automatic test_wrap();
    req(1, 0, 0, 2'd2, 32'hFFFF, 32'h12345678);
    total++; if (bus.sram_addr !== 14'h3FFF) $display("FAIL wr_addr0 got %h exp 3fff", bus.sram_addr); else passed++;
    nop();
    total++; if (bus.sram_addr !== 14'h0000) $display("FAIL wr_addr1 got %h exp 0000", bus.sram_addr); else passed++;
    total++; if (bus.sram_wdata !== 32'h00123456) $display("FAIL wr_wd1 got %h exp 00123456", bus.sram_wdata); else passed++;
    nop();
    total++; if (mem[0] !== 32'h00123456) $display("FAIL wr_mem got %h exp 00123456", mem[0]); else passed++;
  endtask
  task automatic test_reset_midsplit();
    mem[14'h12] = 32'h55555555;
    req(1, 0, 0, 2'd2, 32'h47, 32'hCAFEF00D);
    nop();
    reset = 1'b0;
    #1;
    total++; if (bus.sram_we !== 1'b0) $display("FAIL rs_we got %b exp 0", bus.sram_we); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rs_busy got %b exp 0", bus.busy); else passed++;
    total++; if (bus.sram_addr !== 14'h0 || bus.sram_byteEn !== 4'h0 || bus.sram_wdata !== 32'h0) $display("FAIL rs_bus got addr=%h be=%b wd=%h exp 0", bus.sram_addr, bus.sram_byteEn, bus.sram_wdata); else passed++;
    total++; if (bus.memoryDataRead !== 32'h0) $display("FAIL rs_rdata got %h exp 0", bus.memoryDataRead); else passed++;
    @(negedge clk);
    total++; if (mem[14'h12] !== 32'h55555555) $display("FAIL rs_mem got %h exp 55555555", mem[14'h12]); else passed++;
    reset = 1'b1;
    req(0, 1, 0, 2'd2, 32'h40, 0);
    total++; if (bus.sram_re !== 1'b1 || bus.busy !== 1'b0) $display("FAIL rs_idle got re=%b busy=%b exp 1 0", bus.sram_re, bus.busy); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h8899AABB) $display("FAIL rs_load got %h exp 8899aabb", bus.memoryDataRead); else passed++;
  endtask
  task automatic test_trap();
    req(0, 1, 0, 2'd2, 32'h42, 0);
    total++; if (bus.sram_re !== 1'b0) $display("FAIL tr_re got %b exp 0", bus.sram_re); else passed++;
    total++; if (bus.misaligned !== 1'b1) $display("FAIL tr_mis got %b exp 1", bus.misaligned); else passed++;
    nop();
    total++; if (bus.memoryDataRead !== 32'h0) $display("FAIL tr_data got %h exp 0", bus.memoryDataRead); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL tr_busy got %b exp 0", bus.busy); else passed++;
    req(1, 0, 0, 2'd2, 32'h47, 32'hDEADBEEF);
    total++; if (bus.sram_we !== 1'b0 || bus.misaligned !== 1'b1) $display("FAIL tr_st got we=%b mis=%b exp 0 1", bus.sram_we, bus.misaligned); else passed++;
    nop();
  endtask
  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 32'h0;
    mem[14'h10] = 32'h8899AABB;
    mem[14'h11] = 32'h11223344;
    test_reset();
    test_aligned_load();
    test_subword_loads();
    test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
    test_trap();
`else
    test_split_load();
    test_split_store();
    test_wrap();
    test_reset_midsplit();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the core pipeline's memory port.
- Converts the pipeline's byte-addressed load/store requests (length, store, load, loadUnsigned) into word-addressed accesses on a synchronous single-port SRAM with byte enables.
- Performs byte-lane alignment, sign/zero extension and word-boundary-crossing (split) accesses using a small FSM.
- Returns formatted read data on memoryDataRead one cycle after an aligned request.

Parameters:
- DATA_WIDTH, 32, data and byte-address width. Fixed at 32; the byte-lane logic assumes 4 lanes.
- SRAM_ADDR_WIDTH, 14, word-address width to the SRAM (64 KiB).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- memoryAddress  in  DATA_WIDTH  byte address of request
- memoryDataWrite  in  DATA_WIDTH  store data, right-aligned
- memoryLength  in  2  0=byte, 1=half, 2/3=word
- store  in  1  store request strobe (one cycle)
- load  in  1  load request strobe (one cycle)
- loadUnsigned  in  1  zero-extend (1) or sign-extend (0) sub-word loads
- memoryDataRead  out  DATA_WIDTH  formatted load data
- busy  out  1  split access in progress; requests are ignored while high
- misaligned  out  1  one-cycle pulse: the accepted request crossed a word boundary
- sram_addr  out  SRAM_ADDR_WIDTH  word address
- sram_re  out  1  SRAM read enable
- sram_we  out  1  SRAM write enable
- sram_byteEn  out  4  write byte enables, lane0 = bits 7:0
- sram_wdata  out  DATA_WIDTH  lane-aligned write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_re

Behaviour:
- Byte order is little-endian.
- Request decode:
  - offset = memoryAddress[1:0]; word index = memoryAddress[SRAM_ADDR_WIDTH+1:2].
  - A request is split when offset + bytes(length) > 4.
  - The second word index is word index + 1, modulo 2^SRAM_ADDR_WIDTH (wraps at the top word).
- A request is accepted only when busy=0.
  - If load and store are both asserted: store wins, load is dropped.
- FSM states: IDLE, LOAD_RESP, SPLIT_LD2, SPLIT_LD_RESP, SPLIT_ST2.
- Aligned load at cycle N:
  - sram_re=1 and sram_addr driven combinationally in N.
  - Offset, length and unsigned flag are registered.
  - State LOAD_RESP in N+1, where memoryDataRead = formatted sram_rdata.
- Split load at cycle N:
  - Word A is read in N; first rdata is captured in N+1.
  - SPLIT_LD2 in N+1: read A+1, busy=1.
  - SPLIT_LD_RESP in N+2: memoryDataRead valid, busy=0.
- Aligned store at N:
  - sram_we=1 in N.
  - byteEn = lane mask shifted by offset.
  - wdata = memoryDataWrite << (8·offset).
  - State stays IDLE.
- Split store at N:
  - Compute the 64-bit value {data,mask} << (8·offset) and register the upper half.
  - N: write the low half to word A.
  - SPLIT_ST2 in N+1: write the upper half to A+1, busy=1.
  - N+2: IDLE.
- Load formatting:
  - The 64-bit value {second,first} (aligned case: {0,first}) is shifted right by 8·offset.
  - Take the low 1/2/4 bytes, then sign- or zero-extend per loadUnsigned (ignored for word loads).
- memoryDataRead outside response states holds the last formatted value (hold register, reset 0).
- A new request is accepted in LOAD_RESP and SPLIT_LD_RESP: back-to-back loads are allowed.
- misaligned pulses in the acceptance cycle of any split request.
- Reset (asynchronous, active-low):
  - State goes to IDLE and the hold register clears.
  - All outputs go to 0, including combinational enables: sram_re/we are gated by reset.
  - An in-flight split is abandoned, so the second write of a split store never occurs.
- sram_re and sram_we are never both 1 in the same cycle.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Split requests are not executed: no SRAM enable is asserted.
  - misaligned pulses; split loads return 0 on memoryDataRead in N+1.
  - busy never asserts, and the SPLIT_* states are not compiled.
- When undefined: split handling is as described in Behaviour.

Test Plan:
- Preload word 0x10 = 0x8899AABB; lw @0x40 -> sram_re in N with sram_addr=0x10; memoryDataRead=0x8899AABB in N+1; busy=0 throughout.
- lb @0x41 -> 0xFFFFFFAA; lbu @0x41 -> 0x000000AA; lh @0x42 -> 0xFFFF8899; lhu @0x42 -> 0x00008899.
- With word 0x11 = 0x11223344: lw @0x42 -> misaligned pulse in N; busy=1 in N+1 with sram_addr=0x11; memoryDataRead=0x33448899 in N+2.
- sw 0xDEADBEEF @0x47 -> N: addr 0x11, byteEn 1000, wdata 0xEF000000; N+1: addr 0x12, byteEn 0111, wdata 0x00DEADBE.
- Split store at the top word (@0xFFFF, SRAM_ADDR_WIDTH=14) -> second write to addr 0x0000. Separately, reset asserted in N+1 of a split store -> no second write, all outputs 0, state IDLE.
- With MEM_MISALIGN_TRAP_EN: lw @0x42 -> no sram_re, misaligned=1, memoryDataRead=0 in N+1, busy never high.
